// File: rtl/mips_core_pkg.sv
// Shared core types for the physical register file and rename logic.
package mips_core_pkg;

    localparam int unsigned PHYS_REGS = 32;

    typedef logic [4:0]  preg_tag_t;
    typedef logic [31:0] preg_mask_t;

endpackage : mips_core_pkg

// File: rtl/priority_encoder_32.sv
// 32-input priority encoder. HIGH_PRIORITY=1 selects the lowest matching index,
// 0 the highest. SIGNAL is the input level treated as "set". Index is 0 when
// nothing matches, so callers needing a valid flag must derive it separately.
module priority_encoder_32 #(
    parameter bit HIGH_PRIORITY = 1'b1,
    parameter bit SIGNAL        = 1'b1
) (
    input  logic [31:0] in_vec,
    output logic [4:0]  out_idx
);

    // Scan so that the last match written is the winning index.
    always_comb begin
        out_idx = 5'd0;
        if (HIGH_PRIORITY) begin
            for (int i = 31; i >= 0; i--) begin
                if (in_vec[i] == SIGNAL) out_idx = 5'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (in_vec[i] == SIGNAL) out_idx = 5'(i);
            end
        end
    end

endmodule : priority_encoder_32

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: bitmap of free tags, lowest free tag offered to
// rename, tags returned by commit, one branch checkpoint restored on flush.
module phys_reg_free_list
    import mips_core_pkg::*;
#(
    parameter int unsigned RESERVED = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      alloc_req,
    output logic      alloc_valid,
    output preg_tag_t alloc_tag,
    input  logic      release_valid,
    input  preg_tag_t release_tag,
    input  logic      ckpt_take,
    input  logic      flush,
    output logic [5:0] free_count,
    output logic      empty,
    output logic      err_double_free
);

    // Tags below RESERVED hold the initial architectural mapping.
    localparam preg_mask_t  RESET_MASK  = {PHYS_REGS{1'b1}} << RESERVED;
    localparam logic [5:0]  RESET_COUNT = 6'(PHYS_REGS - RESERVED);
    localparam logic        RESET_EMPTY = (RESERVED == PHYS_REGS);

    preg_mask_t bitmap_q, bitmap_d;
    preg_mask_t ckpt_q, ckpt_d;
    logic [5:0] free_count_q, free_count_d;
    logic       empty_q, empty_d;
    logic       err_q, err_d;
    preg_tag_t  enc_tag;

    logic       alloc_fire;
    logic       rel_ok;
    preg_mask_t alloc_mask;
    preg_mask_t rel_mask;

    priority_encoder_32 #(
        .HIGH_PRIORITY (1'b1),
        .SIGNAL        (1'b1)
    ) u_enc (
        .in_vec  (bitmap_q),
        .out_idx (enc_tag)
    );

    // Valid comes from the bitmap itself: an encoder result of 0 is ambiguous.
    assign alloc_valid     = |bitmap_q;
    assign alloc_tag       = alloc_valid ? enc_tag : '0;
    assign free_count      = free_count_q;
    assign empty           = empty_q;
    assign err_double_free = err_q;

    // Next-state for bitmap, checkpoint, count and error flag.
    always_comb begin
        alloc_fire   = alloc_req && alloc_valid && !flush;
        rel_ok       = release_valid && !bitmap_q[release_tag];
        alloc_mask   = alloc_fire ? (preg_mask_t'(1) << alloc_tag) : '0;
        rel_mask     = rel_ok ? (preg_mask_t'(1) << release_tag) : '0;
        bitmap_d     = bitmap_q;
        ckpt_d       = ckpt_q;
        free_count_d = free_count_q;
        err_d        = err_q | (release_valid && bitmap_q[release_tag]);

        if (flush) begin
            // Committed frees since the checkpoint are already folded into ckpt_q.
            bitmap_d     = ckpt_q | rel_mask;
            ckpt_d       = bitmap_d;
            free_count_d = 6'($countones(bitmap_d));
        end else begin
            bitmap_d     = (bitmap_q & ~alloc_mask) | rel_mask;
            ckpt_d       = ckpt_take ? bitmap_d : (ckpt_q | rel_mask);
            free_count_d = free_count_q + 6'(rel_ok) - 6'(alloc_fire);
        end

        empty_d = (free_count_d == 6'd0);
    end

    // State registers with asynchronous return to the reset mapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q     <= RESET_MASK;
            ckpt_q       <= RESET_MASK;
            free_count_q <= RESET_COUNT;
            empty_q      <= RESET_EMPTY;
            err_q        <= 1'b0;
        end else begin
            bitmap_q     <= bitmap_d;
            ckpt_q       <= ckpt_d;
            free_count_q <= free_count_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
        end
    end

endmodule : phys_reg_free_list

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    import mips_core_pkg::*;

    localparam int RES = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    preg_tag_t  alloc_tag;
    logic       release_valid = 1'b0;
    preg_tag_t  release_tag = '0;
    logic       ckpt_take = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] free_count;
    logic       empty;
    logic       err_double_free;

    int errors = 0;
    int checks = 0;

    // Reference model: free set, checkpoint set, sticky error, tags held by rename.
    bit m_free[32];
    bit m_ckpt[32];
    bit m_err;
    bit m_held[32];

    phys_reg_free_list #(.RESERVED(RES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .release_valid   (release_valid),
        .release_tag     (release_tag),
        .ckpt_take       (ckpt_take),
        .flush           (flush),
        .free_count      (free_count),
        .empty           (empty),
        .err_double_free (err_double_free)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_free[i];
        return n;
    endfunction

    function automatic bit m_any();
        return m_count() != 0;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < 32; i++) if (m_free[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_free[i] = (i >= RES);
            m_ckpt[i] = (i >= RES);
            m_held[i] = (i < RES);
        end
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        alloc_req = 0; release_valid = 0; release_tag = '0; ckpt_take = 0; flush = 0;
        #10;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, update the model across the edge, and end 1ns after it.
    task automatic drive_cycle(input bit areq, input bit rv, input int rtag,
                               input bit ck, input bit fl, input bit chk_held);
        bit fire, relok;
        int t;
        bit nf[32];
        alloc_req     = areq;
        release_valid = rv;
        release_tag   = preg_tag_t'(rtag);
        ckpt_take     = ck;
        flush         = fl;
        t     = m_lowest();
        fire  = areq && m_any() && !fl;
        relok = rv && !m_free[rtag];
        if (rv && m_free[rtag]) m_err = 1'b1;
        if (chk_held && fire) begin
            checks++;
            if (m_held[t]) begin
                errors++;
                $display("FAIL held_reoffer: tag %0d offered while still held", t);
            end
        end
        if (fl) begin
            nf = m_ckpt;
            if (relok) nf[rtag] = 1'b1;
            m_ckpt = nf;
            for (int i = 0; i < 32; i++) m_held[i] = !nf[i];
        end else begin
            nf = m_free;
            if (fire) begin nf[t] = 1'b0; m_held[t] = 1'b1; end
            if (relok) begin nf[rtag] = 1'b1; m_held[rtag] = 1'b0; end
            if (ck) m_ckpt = nf;
            else if (relok) m_ckpt[rtag] = 1'b1;
        end
        m_free = nf;
        @(posedge clk); #1;
        alloc_req = 0; release_valid = 0; ckpt_take = 0; flush = 0;
    endtask

    task automatic check_state(input string name, input bit ev, input int etag,
                               input int efc, input bit eempty, input bit eerr);
        checks++;
        if (alloc_valid !== ev) begin
            errors++; $display("FAIL %s alloc_valid: got %0b want %0b", name, alloc_valid, ev);
        end
        checks++;
        if (ev && alloc_tag !== preg_tag_t'(etag)) begin
            errors++; $display("FAIL %s alloc_tag: got %0d want %0d", name, alloc_tag, etag);
        end
        checks++;
        if (free_count !== 6'(efc)) begin
            errors++; $display("FAIL %s free_count: got %0d want %0d", name, free_count, efc);
        end
        checks++;
        if (empty !== eempty) begin
            errors++; $display("FAIL %s empty: got %0b want %0b", name, empty, eempty);
        end
        checks++;
        if (err_double_free !== eerr) begin
            errors++; $display("FAIL %s err: got %0b want %0b", name, err_double_free, eerr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset", 1'b1, 16, 16, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (alloc_tag !== preg_tag_t'(16 + i) || alloc_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_tag[%0d]: got %0d/%0b want %0d/1", i, alloc_tag, alloc_valid, 16 + i);
            end
            drive_cycle(1, 0, 0, 0, 0, 0);
        end
        check_state("b2b_empty", 1'b0, 0, 0, 1'b1, 1'b0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        check_state("b2b_17th", 1'b0, 0, 0, 1'b1, 1'b0);
        checks++;
        if (alloc_tag !== 5'd0) begin
            errors++; $display("FAIL b2b_tag_zero: got %0d want 0", alloc_tag);
        end
    endtask

    task automatic test_release_empty();
        alloc_req = 1'b1;
        release_valid = 1'b1;
        release_tag = 5'd5;
        #1;
        checks++;
        if (alloc_valid !== 1'b0) begin
            errors++; $display("FAIL rel_no_bypass: alloc_valid got %0b want 0", alloc_valid);
        end
        drive_cycle(1, 1, 5, 0, 0, 0);
        check_state("rel_empty", 1'b1, 5, 1, 1'b0, 1'b0);
    endtask

    task automatic test_ckpt_flush();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, 0, 0, 0);
        check_state("pre_ckpt", 1'b1, 20, 12, 1'b0, 1'b0);
        drive_cycle(0, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 3, 0, 0, 0);
        check_state("post_allocs", 1'b1, 3, 11, 1'b0, 1'b0);
        drive_cycle(1, 0, 0, 0, 1, 0);
        check_state("flush", 1'b1, 3, 13, 1'b0, 1'b0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        check_state("flush_a1", 1'b1, 20, 12, 1'b0, 1'b0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        check_state("flush_a2", 1'b1, 21, 11, 1'b0, 1'b0);
    endtask

    task automatic test_double_free();
        do_reset();
        drive_cycle(0, 1, 25, 0, 0, 0);
        check_state("dbl_free", 1'b1, 16, 16, 1'b0, 1'b1);
        drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_state("dbl_sticky", 1'b1, 16, 16, 1'b0, 1'b1);
        drive_cycle(0, 1, 2, 0, 0, 0);
        check_state("dbl_then_rel", 1'b1, 2, 17, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b1, 16, 16, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_state("after_rst", 1'b1, 16, 16, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int rtag;
        bit areq, rv, ck, fl;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (alloc_valid !== m_any()) begin
                errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", c, alloc_valid, m_any());
            end
            checks++;
            if (alloc_tag !== preg_tag_t'(m_lowest())) begin
                errors++; $display("FAIL rnd_tag @%0d: got %0d want %0d", c, alloc_tag, m_lowest());
            end
            areq = ($urandom_range(99) < 60);
            rtag = $urandom_range(31);
            rv   = ($urandom_range(99) < 50) && !m_free[rtag];
            ck   = ($urandom_range(99) < 10);
            fl   = ($urandom_range(99) < 5);
            drive_cycle(areq, rv, rtag, ck, fl, 1);
            checks++;
            if (free_count !== 6'(m_count())) begin
                errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, free_count, m_count());
            end
            checks++;
            if (empty !== (m_count() == 0)) begin
                errors++; $display("FAIL rnd_empty @%0d: got %0b want %0b", c, empty, m_count() == 0);
            end
            checks++;
            if (err_double_free !== m_err) begin
                errors++; $display("FAIL rnd_err @%0d: got %0b want %0b", c, err_double_free, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_release_empty();
        test_ckpt_flush();
        test_double_free();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_phys_reg_free_list
